// File: rtl/dmem_controller.sv
// Byte/half/word data memory with valid/ready handshake, configurable latency and error reporting.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of forcing alignment.
module dmem_controller #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic              resp_valid,
  output logic [31:0]       read_data,
  output logic              resp_err,
  output logic              busy
);

  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               write_q, unsigned_q;
  logic [1:0]         size_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;

  logic               cur_write, cur_unsigned;
  logic [1:0]         cur_size;
  logic [ADDR_W-1:0]  cur_addr;
  logic [31:0]        cur_wdata;

  logic [IDX_W-1:0]   idx;
  logic [1:0]         lane;
  logic               size_err, range_err, align_err, req_err;
  logic [3:0]         be;
  logic [31:0]        wlanes;
  logic [31:0]        mem_word;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        load_data;
  logic               commit, we;

  logic [31:0]        mem [DEPTH];

  // In IDLE the request is being accepted this edge, so decode the live inputs (needed for LATENCY=1).
  always_comb begin
    if (state_q == IDLE) begin
      cur_write    = req_write;
      cur_unsigned = req_unsigned;
      cur_size     = req_size;
      cur_addr     = address;
      cur_wdata    = write_data;
    end else begin
      cur_write    = write_q;
      cur_unsigned = unsigned_q;
      cur_size     = size_q;
      cur_addr     = addr_q;
      cur_wdata    = wdata_q;
    end
  end

  always_comb begin
    idx       = cur_addr[IDX_W+1:2];
    lane      = cur_addr[1:0];
    size_err  = (cur_size == 2'b11);
    range_err = ((cur_addr >> (IDX_W + 2)) != '0);
`ifdef DMEM_MISALIGN_TRAP_EN
    align_err = ((cur_size == 2'b01) && lane[0]) || ((cur_size == 2'b10) && (lane != 2'b00));
`else
    align_err = 1'b0;
`endif
    req_err   = size_err | range_err | align_err;

    case (cur_size)
      2'b00:   begin be = 4'b0001 << lane;                 wlanes = {4{cur_wdata[7:0]}};  end
      2'b01:   begin be = lane[1] ? 4'b1100 : 4'b0011;     wlanes = {2{cur_wdata[15:0]}}; end
      2'b10:   begin be = 4'b1111;                         wlanes = cur_wdata;            end
      default: begin be = 4'b0000;                         wlanes = cur_wdata;            end
    endcase

    mem_word = mem[idx];
    byte_sel = mem_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

    case (cur_size)
      2'b00:   load_data = {{24{~cur_unsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~cur_unsigned & half_sel[15]}}, half_sel};
      2'b10:   load_data = mem_word;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy = ~req_ready;
  end

  // Store commit and load sampling both happen on the edge that enters RESP.
  always_comb begin
    commit  = (state_d == RESP) && (state_q != RESP);
    we      = commit && cur_write && !req_err;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = req_err;
      rdata_d = (req_err || cur_write) ? 32'h0 : load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      write_q    <= req_write;
      unsigned_q <= req_unsigned;
      size_q     <= req_size;
      addr_q     <= address;
      wdata_q    <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) mem[idx][8*n +: 8] <= wlanes[8*n +: 8];
      end
    end
  end

  assign read_data = rdata_q;
  assign resp_err  = err_q;

endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench for dmem_controller: handshake latency, lane/extension behaviour, errors, mid-request reset.
module tb_dmem_controller;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] address, write_data, read_data;
  logic        resp_valid, resp_err, busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  dmem_controller #(.ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .address      (address),
    .write_data   (write_data),
    .resp_valid   (resp_valid),
    .read_data    (read_data),
    .resp_err     (resp_err),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] r, output logic e);
    int n;
    @(negedge clk);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    address      = a;
    write_data   = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    check("latency", 32'(n), 32'(LATENCY));
    r = read_data;
    e = resp_err;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; address = '0; write_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_read_data", read_data, 32'h0);
    rst_n = 1'b1;

    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'h0);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    check("lw_10", rd, 32'hDEADBEEF);
    check("lw_10_err", 32'(er), 32'd0);
    check("hold_valid", 32'(resp_valid), 32'd0);
    check("hold_rdata", read_data, 32'hDEADBEEF);

    xact(1'b1, 2'b00, 1'b0, 32'h13, 32'hABCDEF80, rd, er);
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er);
    check("lb_13", rd, 32'hFFFFFF80);
    xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er);
    check("lbu_13", rd, 32'h00000080);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    check("lw_10_after_sb", rd, 32'h80ADBEEF);

    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, rd, er);
    xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h55551234, rd, er);
    xact(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er);
    check("lh_22", rd, 32'h00001234);
    xact(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, rd, er);
    check("lh_20", rd, 32'hFFFFF00D);
    xact(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, er);
    check("lhu_20", rd, 32'h0000F00D);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
    check("lw_20", rd, 32'h1234F00D);

    xact(1'b1, 2'b10, 1'b0, 32'h100, 32'h01020304, rd, er);
    xact(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw_102_err", 32'(er), 32'd1);
    check("lw_102_rdata", rd, 32'h0);
`else
    check("lw_102_err", 32'(er), 32'd0);
    check("lw_102_rdata", rd, 32'h01020304);
`endif

    xact(1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h0, rd, er);
    check("range_err", 32'(er), 32'd1);
    check("range_rdata", rd, 32'h0);
    xact(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, rd, er);
    check("size11_err", 32'(er), 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    check("size11_nowrite", rd, 32'h80ADBEEF);
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    check("err_cleared", 32'(er), 32'd0);

    xact(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, rd, er);
    xact(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er);
    check("lw_30", rd, 32'h11223344);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    address = 32'h30; write_data = 32'h55667788; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("busy_in_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_rdata", read_data, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_resp", 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    xact(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er);
    check("lw_30_after_rst", rd, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_controller.md
# dmem_controller

Parametrised data memory for the processor datapath, successor to the single-cycle word memory. Adds byte, halfword and word accesses with little-endian byte lanes, sign or zero extension on loads, and a valid/ready request handshake. Access latency is configurable, and range and alignment errors are reported. It sits between the MEM stage and the load/store unit and accepts one outstanding request at a time.

## Interface
- ADDR_W, 32, byte-address width.
- DEPTH, 256, number of 32-bit words; power of two, 2..65536.
- LATENCY, 2, cycles from request acceptance to response; 1..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- address  input  ADDR_W  byte address.
- write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle response strobe.
- read_data  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  qualified by resp_valid; 1 = request rejected.
- busy  output  1  request in flight (inverse of req_ready).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid is high at a rising edge, the controller latches all req_* inputs, address and write_data, and loads the counter with LATENCY-1. It moves to RESP if LATENCY=1, otherwise to WAIT.
- WAIT: the counter decrements each cycle. At 1 the controller moves to RESP.
- RESP: resp_valid=1 for exactly one cycle, then the controller returns to IDLE.
- The store commits to the array on the edge that enters RESP. Load data is sampled on the same edge.
- Word index is address[log2(DEPTH)+1:2]. Lane is address[1:0]. Byte lane n is bits [8n+7:8n].
- Byte store writes only lane address[1:0]. Half store writes lanes {a[1],0} and {a[1],1}. Word store writes all four lanes.
- Byte load returns the selected byte, extended to 32 bits per req_unsigned. Half load is handled the same way. Word load ignores req_unsigned.
- An error sets resp_err=1, performs no write, and returns read_data=0. Error causes:
  - reserved size;
  - any address bit above the word-index field is nonzero (out of range);
  - misalignment, which depends on Configuration.
- Array contents are not reset.

## Timing
- Reset values: req_ready=1, busy=0, resp_valid=0, resp_err=0, read_data=0, state IDLE, counter 0.
- Latency: a request accepted at edge k produces resp_valid high in the cycle following edge k+LATENCY-1. The earliest next acceptance is edge k+LATENCY+1.
- Throughput: one request per LATENCY+1 cycles.
- Inputs are ignored while req_ready=0. The requester must hold req_valid until it sees req_ready.
- read_data and resp_err hold their values after resp_valid falls, until the next RESP.
- Reset asserted mid-operation: the request is abandoned, no write occurs, and outputs return to reset values immediately.
- A load to the address of the immediately preceding store returns the new data.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: a half access with address[0]=1, or a word access with address[1:0]!=0, gives resp_err=1 and no write.
- Undefined: misaligned low address bits are forced to alignment. Half ignores address[0]; word ignores address[1:0]. No error is raised for alignment.

## Test plan
- Reset, then word store 0xDEADBEEF to 0x10 with LATENCY=2, then word load from 0x10. Store ack: resp_valid in the cycle after edge k+1, resp_err=0. Load: read_data=0xDEADBEEF.
- Byte store 0x80 to 0x13, then byte load 0x13 signed and unsigned, then word load 0x10. Results: 0xFFFFFF80, 0x00000080, 0x80ADBEEF.
- Half store 0x1234 to 0x22, then half load 0x22 signed. Result 0x00001234; lanes 0–1 of word 0x20 are unchanged.
- Word load 0x102 with the macro defined: resp_err=1, read_data=0. Without the macro: returns the word at 0x100.
- Word load at address 4*DEPTH: resp_err=1. Size 11: resp_err=1, no array change.
- Assert rst_n low during WAIT of a store to 0x30, then load 0x30. No resp_valid during the abandoned request; the prior contents are returned.
